// File: rtl/adder_full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : full_adder                                                |
// | Purpose  : single-bit full-adder cell for the ripple-carry chain     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_p;

   assign w_p  = a ^ b;
   assign s    = w_p ^ cin;
   assign cout = (a & b) | (cin & w_p);

endmodule
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adder                                                     |
// | Purpose  : two-stage registered unsigned ripple-carry adder          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] r_a_q;
   logic [WIDTH-1:0] r_b_q;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH:0]   w_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_q <= '0;
         r_b_q <= '0;
      end else begin
         r_a_q <= a;
         r_b_q <= b;
      end
   end

   // Carry-in is tied low; the final carry of the chain becomes cout.
   assign w_c[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
         full_adder u_fa (
            .a   (r_a_q[gi]),
            .b   (r_b_q[gi]),
            .cin (w_c[gi]),
            .s   (w_s[gi]),
            .cout(w_c[gi+1])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else begin
         r_sum  <= w_s;
         r_cout <= w_c[WIDTH];
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_adder                                                  |
// | Purpose  : self-checking bench for the registered adder              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] sum;
   logic         cout;

   int total;
   int bad;
   bit chk_en;

   logic [W:0] model_q[$];
   logic [W:0] model_exp;

   adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a),
      .b    (b),
      .sum  (sum),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got cout/sum=%0d/%0d expected %0d/%0d at %0t",
                  name, act[W], act[W-1:0], exp[W], exp[W-1:0], $time);
      end
   endtask

   // Reference: the full-width sum a+b, delivered one sampling edge after it is taken.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_q.delete();
         model_exp = '0;
      end else begin
         model_q.push_back({1'b0, a} + {1'b0, b});
         if (model_q.size() > 1) model_exp = model_q.pop_front();
      end
   end

   always @(negedge clk) begin
      if (chk_en) check("model", {cout, sum}, model_exp);
   end

   task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb);
      @(posedge clk);
      #2;
      a = va;
      b = vb;
   endtask

   task automatic directed(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [W-1:0] es, input logic ec);
      drive(va, vb);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check(name, {cout, sum}, {ec, es});
   endtask

   logic [W-1:0] pa[4];
   logic [W-1:0] pb[4];
   logic [W:0]   pe[4];

   initial begin
      total  = 0;
      bad    = 0;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      a      = 8'd200;
      b      = 8'd100;

      // Operands present while held in reset must never reach the outputs.
      @(posedge clk);
      chk_en = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_hold", {cout, sum}, 9'd0);
      rst_n = 1'b1;

      directed("no_carry_10_20",   8'd10,  8'd20,  8'd30,  1'b0);
      directed("no_carry_100_100", 8'd100, 8'd100, 8'd200, 1'b0);
      directed("wrap_255_1",       8'd255, 8'd1,   8'd0,   1'b1);
      directed("max_255_255",      8'd255, 8'd255, 8'd254, 1'b1);
      directed("zero_0_0",         8'd0,   8'd0,   8'd0,   1'b0);

      pa = '{8'd10, 8'd255, 8'd255, 8'd3};
      pb = '{8'd20, 8'd1,   8'd255, 8'd4};
      pe = '{9'd30, 9'd256, 9'd510, 9'd7};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #2;
         if (i < 4) begin
            a = pa[i];
            b = pb[i];
         end
         @(negedge clk);
         #1;
         if (i >= 2) check($sformatf("pipe_%0d", i - 2), {cout, sum}, pe[i-2]);
      end

      // Asynchronous clear mid-cycle, checked well before the next edge.
      directed("pre_async", 8'd255, 8'd255, 8'd254, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_clear", {cout, sum}, 9'd0);
      a = 8'd200;
      b = 8'd100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("async_hold", {cout, sum}, 9'd0);
      rst_n = 1'b1;
      directed("after_reset", 8'd128, 8'd128, 8'd0, 1'b1);

      for (int i = 0; i < 1000; i++) begin
         drive(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
